// File: rtl/timer_mc_pkg.sv
// timer_mc: shared register map, TCR field layout and helpers.
// Imported by the prescaler and the top.
package timer_mc_pkg;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TIER_OFF  = 12'h00C;
  localparam logic [11:0] TISR_OFF  = 12'h010;
  localparam logic [11:0] THCSR_OFF = 12'h014;
  localparam logic [11:0] CMP_BASE  = 12'h020;

  localparam int CMP_STRIDE  = 8;
  localparam int MAX_DIV_DEF = 8;

  localparam int TCR_EN      = 0;
  localparam int TCR_DIV_EN  = 1;
  localparam int TCR_AR      = 2;
  localparam int TCR_DIV_LSB = 8;
  localparam int TCR_DIV_MSB = 11;

  localparam logic [31:0] TCR_RST  = 32'h0000_0100;
  localparam logic [31:0] TCR_MASK = 32'h0000_0F07;

  // Byte-lane merge of write data into an old word.
  function automatic logic [31:0] wmerge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_mc_prescaler.sv
// timer_mc: power-of-two prescaler.
// One tick every cycle, or every 2^div_val cycles.
module timer_mc_prescaler
  import timer_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       div_en,
  input  logic [3:0] div_val,
  input  logic       halt,
  output logic       tick
);

  logic [7:0] cnt;
  logic [8:0] lim;
  logic       wrap;
  logic       unused_lim;

  assign lim  = (9'd1 << div_val) - 9'd1;
  assign wrap = (cnt == lim[7:0]);
  assign tick = en & ~halt & (~div_en | wrap);
  assign unused_lim = lim[8];

  // Divider count: cleared when idle, frozen while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!en)
      cnt <= '0;
    else if (!halt)
      cnt <= (div_en & ~wrap) ? cnt + 8'd1 : 8'd0;
  end

endmodule

// File: rtl/timer_mc_top.sv
// timer_mc: APB multi-channel compare timer.
// One shared up-counter, NUM_CH sticky compare channels.
module timer_mc_top
  import timer_mc_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int NUM_CH  = 4,
  parameter int MAX_DIV = MAX_DIV_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic [31:0] tim_prdata,
  output logic        tim_pready,
  output logic        tim_pslverr,
  input  logic        dbg_mode,
  output logic        tim_int
);

  logic [31:0]       tcr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [NUM_CH-1:0] tier;
  logic [NUM_CH-1:0] tisr;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] clr;
  logic              halt_req;
  logic              halt;
  logic              tick;
  logic              reload;

  logic [CNT_W-1:0] cmp    [NUM_CH];
  logic [63:0]      cmp_rd [NUM_CH];

  logic        wr;
  logic        rd;
  logic [11:0] addr;
  logic [11:0] cmp_off;
  logic        cmp_sel;
  logic        cmp_hi;
  logic        sel_tcr;
  logic        sel_tdr0;
  logic        sel_tdr1;
  logic        sel_tier;
  logic        sel_tisr;
  logic        sel_thcsr;

  logic [31:0] tcr_new;
  logic        tcr_bad;
  logic [63:0] cnt64;
  logic [31:0] tdr_lo;
  logic [31:0] tdr_hi;
  logic [31:0] cmp_word;
  logic [31:0] rdata;
  logic        unused_addr;

  assign wr   = tim_psel & tim_penable & tim_pwrite;
  assign rd   = tim_psel & tim_penable & ~tim_pwrite;
  assign addr = {tim_paddr[11:2], 2'b00};
  assign unused_addr = ^tim_paddr[1:0];

  assign sel_tcr   = (addr == TCR_OFF);
  assign sel_tdr0  = (addr == TDR0_OFF);
  assign sel_tdr1  = (addr == TDR1_OFF);
  assign sel_tier  = (addr == TIER_OFF);
  assign sel_tisr  = (addr == TISR_OFF);
  assign sel_thcsr = (addr == THCSR_OFF);

  assign cmp_off = addr - CMP_BASE;
  assign cmp_sel = (addr >= CMP_BASE) &&
                   (cmp_off < 12'(NUM_CH * CMP_STRIDE));
  assign cmp_hi  = cmp_off[2];

  assign tcr_new = wmerge(tcr, tim_pwdata, tim_pstrb) & TCR_MASK;
  assign tcr_bad =
    (int'(tcr_new[TCR_DIV_MSB:TCR_DIV_LSB]) > MAX_DIV) ||
    (tcr[TCR_EN] &&
     ((tcr_new[TCR_DIV_MSB:TCR_DIV_LSB] !=
       tcr[TCR_DIV_MSB:TCR_DIV_LSB]) ||
      (tcr_new[TCR_DIV_EN] != tcr[TCR_DIV_EN])));

  assign halt     = dbg_mode & halt_req;
  assign reload   = tcr[TCR_AR] & (cnt == cmp[0]);
  assign cnt_next = reload ? '0 : cnt + CNT_W'(1);

  assign cnt64  = 64'(cnt);
  assign tdr_lo = wmerge(cnt64[31:0], tim_pwdata, tim_pstrb);
  assign tdr_hi = wmerge(cnt64[63:32], tim_pwdata, tim_pstrb);

  assign clr = (wr & sel_tisr & tim_pstrb[0]) ?
               tim_pwdata[NUM_CH-1:0] : '0;

  timer_mc_prescaler u_presc (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .en      (tcr[TCR_EN]),
    .div_en  (tcr[TCR_DIV_EN]),
    .div_val (tcr[TCR_DIV_MSB:TCR_DIV_LSB]),
    .halt    (halt),
    .tick    (tick)
  );

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic        we;
    logic [63:0] wv;

    assign cmp_rd[n] = 64'(cmp[n]);
    assign we = wr & cmp_sel & (cmp_off[4:3] == 2'(n));
    assign wv = cmp_hi ?
      {wmerge(cmp_rd[n][63:32], tim_pwdata, tim_pstrb),
       cmp_rd[n][31:0]} :
      {cmp_rd[n][63:32],
       wmerge(cmp_rd[n][31:0], tim_pwdata, tim_pstrb)};
    assign hit[n] = tick &
      ((cnt_next == cmp[n]) || (n == 0 && reload));

    // Compare register, byte-writable per word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
        cmp[n] <= '1;
      else if (we)
        cmp[n] <= CNT_W'(wv);
    end
  end

  // Control registers; an illegal TCR write is dropped whole.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcr      <= TCR_RST;
      tier     <= '0;
      halt_req <= 1'b0;
    end else begin
      if (wr & sel_tcr & ~tcr_bad)
        tcr <= tcr_new;
      if (wr & sel_tier & tim_pstrb[0])
        tier <= tim_pwdata[NUM_CH-1:0];
      if (wr & sel_thcsr & tim_pstrb[0])
        halt_req <= tim_pwdata[0];
    end
  end

  // Sticky match flags: a same-cycle set beats the clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      tisr <= '0;
    else
      tisr <= (tisr & ~clr) | hit;
  end

  // Counter: loadable only while stopped, else advances on tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cnt <= '0;
    else if (wr & sel_tdr0 & ~tcr[TCR_EN])
      cnt <= CNT_W'({cnt64[63:32], tdr_lo});
    else if (wr & sel_tdr1 & ~tcr[TCR_EN])
      cnt <= CNT_W'({tdr_hi, cnt64[31:0]});
    else if (tick)
      cnt <= cnt_next;
  end

  // Compare word selected by channel and half.
  always_comb begin
    cmp_word = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (cmp_off[4:3] == 2'(n))
        cmp_word = cmp_hi ? cmp_rd[n][63:32] : cmp_rd[n][31:0];
  end

  // Read decode.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_tcr:   rdata = tcr;
      sel_tdr0:  rdata = cnt64[31:0];
      sel_tdr1:  rdata = cnt64[63:32];
      sel_tier:  rdata = 32'(tier);
      sel_tisr:  rdata = 32'(tisr);
      sel_thcsr: rdata = {30'd0, halt, halt_req};
      cmp_sel:   rdata = cmp_word;
      default:   rdata = '0;
    endcase
  end

  assign tim_prdata  = rd ? rdata : '0;
  assign tim_pready  = 1'b1;
  assign tim_pslverr = wr & sel_tcr & tcr_bad;
  assign tim_int     = |(tisr & tier);

endmodule

// File: doc/timer_mc_top.md
# timer_mc_top

Parametrised multi-channel APB timer, successor to the single-compare 64-bit timer. One free-running up-counter of configurable width is driven by a power-of-two prescaler and compared against NUM_CH independent compare registers. Each channel has its own sticky status and enable, so any channel match can raise the single OR-combined interrupt line. Channel 0 can optionally auto-reload the counter for periodic operation. Debug halt is supported. The block sits on the peripheral APB bus alongside the existing timer.

## Interface
- CNT_W, 64: counter width, 32..64; bits above CNT_W read 0 and ignore writes.
- NUM_CH, 4: compare channels, 1..4.
- MAX_DIV, 8: largest legal div_val.
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tim_psel, tim_penable, tim_pwrite  in  1 each  APB control.
- tim_paddr  in  12  byte address; bits [1:0] ignored.
- tim_pwdata  in  32  write data.
- tim_pstrb  in  4  byte write enables.
- tim_prdata  out  32  read data; 0 outside read access phase.
- tim_pready  out  1  always 1 (zero wait state).
- tim_pslverr  out  1  error flag, valid in access phase.
- dbg_mode  in  1  debug mode from the CPU.
- tim_int  out  1  OR of (TISR & TIER).

## Operation
- Register map:
  - 0x000 TCR: [0] timer_en, [1] div_en, [2] auto_reload, [11:8] div_val. Reset 0x0000_0100.
  - 0x004 TDR0: counter low. 0x008 TDR1: counter high.
  - 0x00C TIER: [NUM_CH-1:0] enables.
  - 0x010 TISR: [NUM_CH-1:0] sticky match flags, write-1-to-clear.
  - 0x014 THCSR: [0] halt_req (RW), [1] halt_ack (RO).
  - 0x020+8n / 0x024+8n: CMPn low / high. Reset 0xFFFF_FFFF each.
  - Every other offset, and channels n ≥ NUM_CH: RAZ/WI, pslverr=0.
- Writes commit only at the access phase (psel & penable & pwrite), per byte by pstrb. Reads return current register values.
- Illegal TCR writes set pslverr=1 and the whole write is dropped:
  - div_val > MAX_DIV;
  - any change of div_val or div_en while timer_en=1.
- TDR0/TDR1 writes are ignored while timer_en=1 (pslverr=0).
- Tick generation:
  - div_en=0: tick every cycle.
  - div_en=1: tick every 2^div_val cycles.
- Counter increments by 1 on a tick when timer_en=1 and not halted. It wraps from all-ones to 0, carrying from low word into high word.
- Match n: on a tick where the next counter value equals CMPn, TISR[n] is set.
- Auto-reload: if auto_reload=1 and the counter equals CMP0 on a tick, the counter loads 0 instead of incrementing, and TISR[0] is set.
- Halt: halt = dbg_mode & halt_req. While halted, the counter and prescaler freeze and halt_ack=1.
- Same-cycle priorities:
  - set and W1C of the same TISR bit: set wins;
  - auto-reload and TDR write cannot collide (write ignored while enabled).

## Timing
- APB: single access phase, pready=1. prdata and pslverr are combinational in the access phase.
- A register write is visible to a read starting the next cycle.
- Writing timer_en 0→1: first tick at most 2^div_val cycles later. Counter value = start + N after N ticks (N cycles when div_en=0).
- Writing timer_en 1→0: prescaler clears to 0 the next cycle; the counter holds.
- TISR is set 1 cycle after the match tick. tim_int rises the same cycle TISR is set (if enabled), and falls the cycle after the W1C write.
- Reset (async, any time): every register returns to its reset value; prescaler=0; counter=0; tim_int=0; prdata=0; pslverr=0.

## Structure
- Package timer_mc_pkg holds:
  - register offset localparams;
  - TCR field positions;
  - MAX_DIV;
  - the CMP stride (8).
- Sub-module timer_mc_prescaler: inputs en, div_en, div_val, halt; output tick. Internal 8-bit counter cleared when en=0.
- Top holds: the APB decode, the register file, the counter, and a generate loop over NUM_CH compare channels.

## Test plan
- Reset defaults:
  - TCR=0x100;
  - TDR0/1, TIER, TISR, THCSR = 0;
  - CMPn = 0xFFFF_FFFF;
  - read of 0x060 = 0, pslverr=0.
- Prescaled count: TDR=0, div_en=1, div_val=4, enable, wait 80 cycles -> TDR0=5. Writing div_val=9 -> pslverr=1 and TCR unchanged.
- Multi-channel matches:
  - setup: CMP0=10, CMP1=20, CMP2=30, TIER=0b101, enable;
  - result: TISR=0b111 by cycle 35, tim_int=1;
  - W1C 0b101 -> tim_int=0.
- Auto-reload: CMP0=15, auto_reload=1, TIER[0]=1 -> counter cycles 0..15. After 64 cycles, TISR[0] has been set; counter ≤ 15.
- Wrap and halt:
  - carry: TDR0=0xFFFF_FFF0, TDR1=0, enable, 32 cycles -> TDR1=1, TDR0=0x10;
  - halt: dbg_mode=1, halt_req=1 -> halt_ack=1 and TDR0 frozen for 50 cycles;
  - resume: halt_req=0 -> counting resumes.
- Protection and reset: write TDR0=0xDEADBEEF while enabled -> ignored. Assert sys_rst_n=0 mid-count -> all defaults within the same cycle.
